// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Receive side of the 8N1 serial link (start 0, 8 data bits
//                LSB first, stop 1, idle high). Synchronizes the rx line,
//                samples each bit near its centre, rebuilds the byte and
//                presents it on a valid/ready handshake. Reports framing
//                errors and overruns as one-cycle pulses.
//  Ports       : clk       - clock, all logic on posedge
//                rst       - synchronous active-high reset
//                rx        - serial line, may be asynchronous to clk
//                data      - received byte, stable while valid=1
//                valid     - data holds an unconsumed byte
//                ready     - consumer takes data when valid&ready at posedge
//                frame_err - one-cycle pulse, stop-bit sample was 0
//                overrun   - one-cycle pulse, byte dropped because valid=1
//                busy      - receiver is in any state other than IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int PW     = $clog2(CLKS_PER_BIT + 1);
    localparam int C_HALF = (CLKS_PER_BIT - 1) / 2;

    // Phase counter holds the number of cycles still to wait before the
    // next sample; a sample is taken when it reads zero.
    localparam logic [PW-1:0] C_BIT_RELOAD  = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] C_HALF_RELOAD = PW'((C_HALF > 0) ? (C_HALF - 1) : 0);
    localparam logic [PW-1:0] C_PHASE_ONE   = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;

    logic                   rx_s;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d      = sync_q;
        state_d     = state_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        sync_d[0] = rx;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        // Consumer handshake; a byte landing this same cycle overrides below.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    bit_cnt_d = 3'd0;
                    if (C_HALF == 0) begin
                        // Start sample coincides with the first low cycle,
                        // and it is already known to be 0.
                        state_d = S_DATA;
                        phase_d = C_BIT_RELOAD;
                    end else begin
                        state_d = S_START;
                        phase_d = C_HALF_RELOAD;
                    end
                end
            end

            S_START: begin
                if (phase_q == '0) begin
                    if (rx_s) begin
                        // Glitch shorter than half a bit: ignore it.
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        phase_d = C_BIT_RELOAD;
                    end
                end else begin
                    phase_d = phase_q - C_PHASE_ONE;
                end
            end

            S_DATA: begin
                if (phase_q == '0) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    phase_d   = C_BIT_RELOAD;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    phase_d = phase_q - C_PHASE_ONE;
                end
            end

            S_STOP: begin
                if (phase_q == '0) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                        if (!valid_q || ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    phase_d = phase_q - C_PHASE_ONE;
                end
            end

            S_WAIT_HIGH: begin
                // Hold off until the line is released so a break does not
                // look like a stream of new start bits.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '1;
            state_q     <= S_IDLE;
            phase_q     <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire
